main_mem_responder: RTL and testbench
=====================================

MAIN_MEM_RESPONDER -- requirements
Module: main_mem_responder

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32, byte address width of mem_add.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width.
REQ-003 SHALL have parameter MEM_DEPTH, default 1024, word count; power of two.
REQ-004 SHALL have parameter LATENCY, default 4, cycles from request acceptance to response; legal range >= 1.
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1; reset is asynchronous and active-low.
REQ-007 SHALL have port mem_add, input, ADDRESS_WIDTH, byte address of the request.
REQ-008 SHALL have port wb_valid, input, 1, writeback request from the cache; driven by the cache's data_ready_main_mem.
REQ-009 SHALL have port wb_data, input, DATA_WIDTH, writeback data; driven by the cache's data_out_main_mem.
REQ-010 SHALL have port rd_req, input, 1, refill request from the cache.
REQ-011 SHALL have port rd_data, output, DATA_WIDTH, refill data; drives the cache's data_in_main_mem.
REQ-012 SHALL have port rd_valid, output, 1, one-cycle refill strobe; drives the cache's write_en_main_mem.
REQ-013 SHALL have port wb_ack, output, 1, one-cycle writeback-committed strobe.
REQ-014 SHALL have port busy, output, 1, high whenever the FSM is not IDLE.

Function
REQ-015 SHALL use FSM states IDLE, WRITE, READ, RESP.
REQ-016 SHALL sample requests only in IDLE; requests outside IDLE are ignored, and the requester holds them until wb_ack or rd_valid.
REQ-017 SHALL give wb_valid priority over rd_req when both are high in the same IDLE cycle; the read is served after the write completes.
REQ-018 SHALL latch word index mem_add[log2(MEM_DEPTH)+1:2] and wb_data on acceptance; higher address bits are ignored (address wraps modulo MEM_DEPTH); low two bits are ignored.
REQ-019 SHALL on write acceptance at edge T: IDLE->WRITE, load latency counter with LATENCY-1, then decrement each cycle.
REQ-020 SHALL in WRITE at counter 0: commit the word to the array, pulse wb_ack for exactly one cycle, and return to IDLE; wb_ack is therefore high in cycle T+LATENCY.
REQ-021 SHALL on read acceptance: IDLE->READ, count identically, issue the array read at counter 0, and move to RESP.
REQ-022 SHALL in RESP: drive rd_data with the array word, pulse rd_valid for one cycle at T+LATENCY, then return to IDLE.
REQ-023 SHALL hold rd_data stable from the rd_valid cycle until the next rd_valid.
REQ-024 SHALL return on a read the data of a write to the same word whose wb_ack has already pulsed (read-after-write coherent).
REQ-025 SHALL allow back-to-back transactions: a new request is acceptable in the cycle after wb_ack or rd_valid.
REQ-026 SHALL size the latency counter as clog2(LATENCY+1) bits; with LATENCY=1 the WRITE and READ states last one cycle.

Reset
REQ-027 SHALL on reset low immediately force state to IDLE, the counter to 0, rd_data to 0, and rd_valid, wb_ack and busy to 0.
REQ-028 SHALL abort an in-flight transaction on reset mid-operation: no array write, no strobe; array contents are not cleared.

Configuration
REQ-029 SHALL, with macro MAIN_MEM_PARITY_EN defined, store an even-parity bit per word, check it on read, and add output port rd_err (1 bit, reset 0) pulsed together with rd_valid on a mismatch.
REQ-030 SHALL, without MAIN_MEM_PARITY_EN, have no parity storage and no rd_err port.

Structure
REQ-031 SHALL place the state enum (IDLE/WRITE/READ/RESP) and the default LATENCY and MEM_DEPTH constants in package main_mem_pkg.
REQ-032 SHALL instantiate one sub-module, main_mem_array: a synchronous single-port RAM (one read/write port, write enable, registered read data).

Verification
REQ-033 SHALL cover: reset, then wb_valid=1, mem_add=0x40, wb_data=0xDEADBEEF -> busy from the next cycle, wb_ack one cycle at acceptance+4, no rd_valid.
REQ-034 SHALL cover: after REQ-033, rd_req=1, mem_add=0x40 -> rd_valid one cycle at acceptance+4 with rd_data=0xDEADBEEF.
REQ-035 SHALL cover: wb_valid and rd_req together, mem_add=0x80, wb_data=0x12345678 -> wb_ack first, rd_valid afterwards with rd_data=0x12345678.
REQ-036 SHALL cover: mem_add=0x1040 with MEM_DEPTH=1024 -> aliases word 0x10, so rd_data returns the word written at 0x40.
REQ-037 SHALL cover: reset low two cycles after a write acceptance to 0xC0 -> outputs 0 immediately, no wb_ack, and a later read of 0xC0 returns the prior contents.
REQ-038 SHALL cover, with MAIN_MEM_PARITY_EN: a stored parity bit is forced wrong by the bench, then read -> rd_err=1 in the same cycle as rd_valid.

Source files
------------

// File: rtl/main_mem_pkg.sv
// Shared types and default constants for the main-memory responder.
// Optional feature macro used by this slice: MAIN_MEM_PARITY_EN.
package main_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam int unsigned DEFAULT_ADDRESS_WIDTH = 32;
  localparam int unsigned DEFAULT_DATA_WIDTH    = 32;
  localparam int unsigned DEFAULT_MEM_DEPTH     = 1024;
  localparam int unsigned DEFAULT_LATENCY       = 4;

endpackage

// File: rtl/main_mem_responder_if.sv
// Cache <-> main-memory bus: writeback and refill handshakes.
// With MAIN_MEM_PARITY_EN defined the responder also drives rd_err.
interface main_mem_responder_if #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32
);

  logic [ADDRESS_WIDTH-1:0] mem_add;
  logic                     wb_valid;
  logic [DATA_WIDTH-1:0]    wb_data;
  logic                     rd_req;
  logic [DATA_WIDTH-1:0]    rd_data;
  logic                     rd_valid;
  logic                     wb_ack;
  logic                     busy;
`ifdef MAIN_MEM_PARITY_EN
  logic                     rd_err;
`endif

  // Cache side: issues requests, consumes strobes.
  modport master (
    output mem_add, wb_valid, wb_data, rd_req,
    input  rd_data, rd_valid, wb_ack, busy
`ifdef MAIN_MEM_PARITY_EN
    , input rd_err
`endif
  );

  // Memory side: the responder.
  modport slave (
    input  mem_add, wb_valid, wb_data, rd_req,
    output rd_data, rd_valid, wb_ack, busy
`ifdef MAIN_MEM_PARITY_EN
    , output rd_err
`endif
  );

endinterface

// File: rtl/main_mem_array.sv
// Synchronous single-port RAM: one shared read/write port, write enable,
// registered read data that holds its value until the next read.
module main_mem_array #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;

  // Storage write on an enabled write cycle.
  // NOTE: the storage array has no reset; clearing it would need a reset
  // port on every word and would stop it mapping onto a RAM macro.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem_q[addr] <= wdata;
    end
  end

  // Next read data: only an enabled read updates it, so it stays stable.
  // NOTE: every variable assigned here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    rdata_d = rdata_q;
    if (en && !we) begin
      rdata_d = mem_q[addr];
    end
  end

  // Read-data register, cleared by reset.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/main_mem_responder.sv
// Fixed-latency main-memory model answering cache writebacks and refills.
// Optional feature: define MAIN_MEM_PARITY_EN for per-word even parity and
// an rd_err strobe alongside rd_valid.
module main_mem_responder
  import main_mem_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int unsigned DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int unsigned MEM_DEPTH     = DEFAULT_MEM_DEPTH,
  parameter int unsigned LATENCY       = DEFAULT_LATENCY
) (
  input  logic                 clk,
  input  logic                 reset,
  main_mem_responder_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
  localparam int unsigned CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
`ifdef MAIN_MEM_PARITY_EN
  localparam int unsigned WORD_W = DATA_WIDTH + 1;
`else
  localparam int unsigned WORD_W = DATA_WIDTH;
`endif

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  wb_ack_q, wb_ack_d;
  logic                  rd_valid_q, rd_valid_d;

  logic                  mem_en;
  logic                  mem_we;
  logic [WORD_W-1:0]     mem_wdata;
  logic [WORD_W-1:0]     mem_rdata;

  // Address bits outside the word index are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.mem_add[ADDRESS_WIDTH-1:IDX_W+2], bus.mem_add[1:0]};

  // FSM next state: accept in IDLE (writeback first), count down, then
  // touch the array and raise the matching one-cycle strobe.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    wb_ack_d   = 1'b0;
    rd_valid_d = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.wb_valid) begin
          state_d = WRITE;
          cnt_d   = CNT_INIT;
          idx_d   = bus.mem_add[IDX_W+1:2];
          wdata_d = bus.wb_data;
        end else if (bus.rd_req) begin
          state_d = READ;
          cnt_d   = CNT_INIT;
          idx_d   = bus.mem_add[IDX_W+1:2];
        end
      end
      WRITE: begin
        if (cnt_q == '0) begin
          mem_en   = 1'b1;
          mem_we   = 1'b1;
          wb_ack_d = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      READ: begin
        if (cnt_q == '0) begin
          mem_en     = 1'b1;
          rd_valid_d = 1'b1;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and registered strobes; reset aborts any transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
      wb_ack_q   <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      wb_ack_q   <= wb_ack_d;
      rd_valid_q <= rd_valid_d;
    end
  end

`ifdef MAIN_MEM_PARITY_EN
  assign mem_wdata  = {^wdata_q, wdata_q};
  assign bus.rd_err = rd_valid_q & (^mem_rdata);
`else
  assign mem_wdata  = wdata_q;
`endif

  main_mem_array #(
    .DEPTH (MEM_DEPTH),
    .WIDTH (WORD_W)
  ) u_array (
    .clk   (clk),
    .rst_n (reset),
    .en    (mem_en),
    .we    (mem_we),
    .addr  (idx_q),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  assign bus.rd_data  = mem_rdata[DATA_WIDTH-1:0];
  assign bus.rd_valid = rd_valid_q;
  assign bus.wb_ack   = wb_ack_q;
  assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_main_mem_responder.sv
// Directed bench for main_mem_responder (LATENCY=4, MEM_DEPTH=1024).
// Define MAIN_MEM_PARITY_EN to also exercise the parity error path.
module tb_main_mem_responder;

  localparam int unsigned LAT = 4;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  main_mem_responder_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();

  main_mem_responder #(
    .ADDRESS_WIDTH (32),
    .DATA_WIDTH    (32),
    .MEM_DEPTH     (1024),
    .LATENCY       (LAT)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Writeback: accept on the first edge, wb_ack exactly LAT cycles later.
  task automatic write_txn(input logic [31:0] addr, input logic [31:0] data);
    bus.mem_add  = addr;
    bus.wb_data  = data;
    bus.wb_valid = 1'b1;
    tick();
    check("wr_busy", 64'(bus.busy), 64'd1);
    for (int i = 1; i <= int'(LAT); i++) begin
      tick();
      check("wr_ack", 64'(bus.wb_ack), 64'(i == int'(LAT)));
      check("wr_no_rdv", 64'(bus.rd_valid), 64'd0);
    end
    bus.wb_valid = 1'b0;
    tick();
    check("wr_ack_end", 64'(bus.wb_ack), 64'd0);
    check("wr_idle", 64'(bus.busy), 64'd0);
  endtask

  // Refill: accept on the first edge, rd_valid exactly LAT cycles later.
  task automatic read_txn(input logic [31:0] addr, input logic [31:0] exp, input logic exp_err);
    bus.mem_add = addr;
    bus.rd_req  = 1'b1;
    tick();
    check("rd_busy", 64'(bus.busy), 64'd1);
    for (int i = 1; i <= int'(LAT); i++) begin
      tick();
      check("rd_valid", 64'(bus.rd_valid), 64'(i == int'(LAT)));
    end
    check("rd_data", 64'(bus.rd_data), 64'(exp));
`ifdef MAIN_MEM_PARITY_EN
    check("rd_err", 64'(bus.rd_err), 64'(exp_err));
`else
    if (exp_err) $display("note: parity disabled, rd_err not checked");
`endif
    bus.rd_req = 1'b0;
    tick();
    check("rd_valid_end", 64'(bus.rd_valid), 64'd0);
    check("rd_data_hold", 64'(bus.rd_data), 64'(exp));
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.mem_add  = '0;
    bus.wb_valid = 1'b0;
    bus.wb_data  = '0;
    bus.rd_req   = 1'b0;
    #1;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_ack", 64'(bus.wb_ack), 64'd0);
    check("rst_rdv", 64'(bus.rd_valid), 64'd0);
    check("rst_data", 64'(bus.rd_data), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Basic writeback then read-after-write of the same word.
    write_txn(32'h40, 32'hDEADBEEF);
    read_txn(32'h40, 32'hDEADBEEF, 1'b0);

    // Simultaneous requests: write wins, read follows and sees the new data.
    bus.mem_add  = 32'h80;
    bus.wb_data  = 32'h12345678;
    bus.wb_valid = 1'b1;
    bus.rd_req   = 1'b1;
    tick();
    check("both_busy", 64'(bus.busy), 64'd1);
    for (int i = 1; i <= int'(LAT); i++) begin
      tick();
      check("both_ack", 64'(bus.wb_ack), 64'(i == int'(LAT)));
      check("both_no_rdv", 64'(bus.rd_valid), 64'd0);
    end
    bus.wb_valid = 1'b0;
    tick();
    check("both_rd_accept", 64'(bus.busy), 64'd1);
    check("both_ack_end", 64'(bus.wb_ack), 64'd0);
    for (int i = 1; i <= int'(LAT); i++) begin
      tick();
      check("both_rdv", 64'(bus.rd_valid), 64'(i == int'(LAT)));
    end
    check("both_data", 64'(bus.rd_data), 64'h12345678);
    bus.rd_req = 1'b0;
    tick();
    check("both_rdv_end", 64'(bus.rd_valid), 64'd0);

    // Address 0x1040 wraps onto word 0x10 (byte 0x40).
    read_txn(32'h1040, 32'hDEADBEEF, 1'b0);

    // Abort a write to 0xC0 two cycles after acceptance.
    write_txn(32'hC0, 32'hA5A5A5A5);
    read_txn(32'hC0, 32'hA5A5A5A5, 1'b0);
    bus.mem_add  = 32'hC0;
    bus.wb_data  = 32'h5555AAAA;
    bus.wb_valid = 1'b1;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_ack", 64'(bus.wb_ack), 64'd0);
    check("abort_rdv", 64'(bus.rd_valid), 64'd0);
    check("abort_data", 64'(bus.rd_data), 64'd0);
    bus.wb_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("abort_no_ack", 64'(bus.wb_ack), 64'd0);
    end
    read_txn(32'hC0, 32'hA5A5A5A5, 1'b0);

`ifdef MAIN_MEM_PARITY_EN
    // Corrupt the stored parity of word 0xC0 (byte 0x300), then read it.
    write_txn(32'h300, 32'h0F0F0F01);
    dut.u_array.mem_q[192][32] = ~dut.u_array.mem_q[192][32];
    read_txn(32'h300, 32'h0F0F0F01, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
